// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl_if
// Purpose  : CPU-side register window and Ireq/Iack handshake of int_ctrl.
//            master = CPU / MIO_BUS side, slave = int_ctrl.
// Signals  : we_i, addr_i, wdata_i  register write strobe, select, data
//            rdata_o                combinational register read
//            Ireq_o, Iack_i         interrupt request / acknowledge pulse
//            cause_o, active_o      ID in service, in-service flag
// Revision : 1.0  initial release
// ============================================================================
interface int_ctrl_if;
   logic        we_i;
   logic [1:0]  addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        Ireq_o;
   logic        Iack_i;
   logic [1:0]  cause_o;
   logic        active_o;

   modport master (
      output we_i, addr_i, wdata_i, Iack_i,
      input  rdata_o, Ireq_o, cause_o, active_o
   );

   modport slave (
      input  we_i, addr_i, wdata_i, Iack_i,
      output rdata_o, Ireq_o, cause_o, active_o
   );
endinterface
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl
// Purpose  : Four-source interrupt controller for the multi-cycle CPU.
//            Synchronises raw sources, latches them into PENDING (edge or
//            level per source), masks them, picks the lowest index and
//            drives a single Ireq/Iack pair with a readable cause.
// Ports    : Clk_CPU  CPU clock, rising edge
//            rst      asynchronous active-high reset
//            irq_i    raw source lines (any clock domain)
//            bus      int_ctrl_if.slave: register window + handshake
// Registers: 0 MASK (rw), 1 PENDING (r, w1c edge bits),
//            2 CAUSE {active,29'b0,cause} (any write = EOI), 3 EDGE (rw)
// Revision : 1.0  initial release
// ============================================================================
module int_ctrl #(
   parameter int                N_SRC        = 4,
   parameter logic [N_SRC-1:0]  DEFAULT_MASK = 4'b0000,
   parameter logic [N_SRC-1:0]  DEFAULT_EDGE = 4'b1111
) (
   input  wire logic             Clk_CPU,
   input  wire logic             rst,
   input  wire logic [N_SRC-1:0] irq_i,
   int_ctrl_if.slave             bus
);

   localparam logic [1:0] C_ADDR_MASK  = 2'd0;
   localparam logic [1:0] C_ADDR_PEND  = 2'd1;
   localparam logic [1:0] C_ADDR_CAUSE = 2'd2;
   localparam logic [1:0] C_ADDR_EDGE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [N_SRC-1:0] r_sync1;
   logic [N_SRC-1:0] r_sync2;
   logic [N_SRC-1:0] r_hist;
   logic [N_SRC-1:0] r_mask;
   logic [N_SRC-1:0] r_edge;
   logic [N_SRC-1:0] r_pending;
   logic [1:0]       r_cause;

   logic [N_SRC-1:0] w_rise;
   logic [N_SRC-1:0] w_elig;
   logic [N_SRC-1:0] w_win_oh;
   logic [1:0]       w_win;
   logic [N_SRC-1:0] w_clr;
   logic [N_SRC-1:0] w_pend_nxt;
   logic             w_take;
   logic             w_eoi;
   logic             w_wr_mask;
   logic             w_wr_pend;
   logic             w_wr_edge;
   logic             w_unused_wdata;

   assign w_wr_mask = bus.we_i && (bus.addr_i == C_ADDR_MASK);
   assign w_wr_pend = bus.we_i && (bus.addr_i == C_ADDR_PEND);
   assign w_eoi     = bus.we_i && (bus.addr_i == C_ADDR_CAUSE);
   assign w_wr_edge = bus.we_i && (bus.addr_i == C_ADDR_EDGE);

   assign w_unused_wdata = ^bus.wdata_i[31:N_SRC];

   // -------------------------------------------------------------------------
   // Two-flop synchroniser followed by a history flop for edge detection
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk_CPU or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_hist  <= '0;
      end else begin
         r_sync1 <= irq_i;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   assign w_rise = r_sync2 & ~r_hist;

   // -------------------------------------------------------------------------
   // Priority: isolate the lowest set bit, then encode it
   // -------------------------------------------------------------------------
   assign w_elig   = r_pending & r_mask;
   assign w_win_oh = w_elig & (~w_elig + 1'b1);

   always_comb begin
      w_win = 2'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_elig[i]) w_win = 2'(i);
      end
   end

   // -------------------------------------------------------------------------
   // Pending bits. Edge sources: a new rising edge beats any clear in the
   // same cycle. Level sources simply follow the synchronised line.
   // -------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < N_SRC; i++) begin : g_src
         assign w_clr[i] = (w_wr_pend & bus.wdata_i[i]) | (w_take & w_win_oh[i]);
         assign w_pend_nxt[i] = r_edge[i] ? (w_rise[i] | (r_pending[i] & ~w_clr[i]))
                                          : r_sync2[i];
      end
   endgenerate

   always_ff @(posedge Clk_CPU or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_mask    <= DEFAULT_MASK;
         r_edge    <= DEFAULT_EDGE;
      end else begin
         r_pending <= w_pend_nxt;
         if (w_wr_mask) r_mask <= bus.wdata_i[N_SRC-1:0];
         if (w_wr_edge) r_edge <= bus.wdata_i[N_SRC-1:0];
      end
   end

   // -------------------------------------------------------------------------
   // Request state machine
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk_CPU or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cause <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) r_cause <= w_win;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_elig != '0) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            // Acknowledge wins over a request that vanished this same cycle
            if (bus.Iack_i) begin
               w_take      = 1'b1;
               w_state_nxt = S_SERVICE;
            end else if (w_elig == '0) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SERVICE: begin
            if (w_eoi) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.Ireq_o   = (r_state == S_REQ);
   assign bus.active_o = (r_state == S_SERVICE);
   assign bus.cause_o  = r_cause;

   // -------------------------------------------------------------------------
   // Combinational register read
   // -------------------------------------------------------------------------
   always_comb begin
      bus.rdata_o = 32'd0;
      case (bus.addr_i)
         C_ADDR_MASK:  bus.rdata_o = {{(32-N_SRC){1'b0}}, r_mask};
         C_ADDR_PEND:  bus.rdata_o = {{(32-N_SRC){1'b0}}, r_pending};
         C_ADDR_CAUSE: bus.rdata_o = {(r_state == S_SERVICE), 29'd0, r_cause};
         C_ADDR_EDGE:  bus.rdata_o = {{(32-N_SRC){1'b0}}, r_edge};
         default:      bus.rdata_o = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ctrl
// Purpose  : Self-checking bench for int_ctrl. A cycle-level behavioural
//            model (delay line of sampled sources, pending/mask/edge words,
//            an integer service mode) predicts every output each cycle.
//            Directed scenarios precede a long randomized run.
// Revision : 1.0  initial release
// ============================================================================
module tb_int_ctrl;

   logic       Clk_CPU = 1'b0;
   logic       rst     = 1'b1;
   logic [3:0] irq     = 4'd0;

   int_ctrl_if bus ();

   int_ctrl #(
      .N_SRC        (4),
      .DEFAULT_MASK (4'b0000),
      .DEFAULT_EDGE (4'b1111)
   ) dut (
      .Clk_CPU (Clk_CPU),
      .rst     (rst),
      .irq_i   (irq),
      .bus     (bus.slave)
   );

   always #5 Clk_CPU = ~Clk_CPU;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   // m_mode: 0 = idle, 1 = request outstanding, 2 = in service
   logic [3:0] m_seen [0:2];   // source value sampled 1, 2, 3 edges ago
   logic [3:0] m_mask, m_edge, m_pend;
   logic [1:0] m_cause;
   int         m_mode;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) m_seen[k] = 4'd0;
      m_mask  = 4'b0000;
      m_edge  = 4'b1111;
      m_pend  = 4'd0;
      m_cause = 2'd0;
      m_mode  = 0;
   endtask

   task automatic model_step(input logic [3:0] irq_v, input logic we_v, input logic [1:0] a,
                             input logic [31:0] wd, input logic ack_v);
      logic [3:0] lvl, prev, elig, npend;
      int         win;
      bit         take;
      lvl  = m_seen[1];
      prev = m_seen[2];
      elig = m_pend & m_mask;
      win  = lowest(elig);
      take = (m_mode == 1) && ack_v;
      for (int i = 0; i < 4; i++) begin
         if (m_edge[i]) begin
            if (lvl[i] && !prev[i])
               npend[i] = 1'b1;
            else if ((we_v && a == 2'd1 && wd[i]) || (take && elig != 0 && win == i))
               npend[i] = 1'b0;
            else
               npend[i] = m_pend[i];
         end else begin
            npend[i] = lvl[i];
         end
      end
      case (m_mode)
         0: if (elig != 0) m_mode = 1;
         1: begin
            if (take) begin
               m_cause = 2'(win);
               m_mode  = 2;
            end else if (elig == 0) m_mode = 0;
         end
         default: if (we_v && a == 2'd2) m_mode = 0;
      endcase
      m_pend = npend;
      if (we_v && a == 2'd0) m_mask = wd[3:0];
      if (we_v && a == 2'd3) m_edge = wd[3:0];
      m_seen[2] = m_seen[1];
      m_seen[1] = m_seen[0];
      m_seen[0] = irq_v;
   endtask

   function automatic logic [31:0] model_rdata(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_mask};
         2'd1:    return {28'd0, m_pend};
         2'd2:    return {(m_mode == 2), 29'd0, m_cause};
         default: return {28'd0, m_edge};
      endcase
   endfunction

   task automatic check_outputs();
      check_val("ireq",   {31'd0, bus.Ireq_o},   {31'd0, (m_mode == 1)});
      check_val("active", {31'd0, bus.active_o}, {31'd0, (m_mode == 2)});
      check_val("cause",  {30'd0, bus.cause_o},  {30'd0, m_cause});
      check_val("rdata",  bus.rdata_o,           model_rdata(bus.addr_i));
   endtask

   // One clock cycle: drive at the falling edge, model the rising edge,
   // check at the next falling edge.
   task automatic step(input logic [3:0] irq_v, input logic we_v, input logic [1:0] a,
                       input logic [31:0] wd, input logic ack_v);
      irq         = irq_v;
      bus.we_i    = we_v;
      bus.addr_i  = a;
      bus.wdata_i = wd;
      bus.Iack_i  = ack_v;
      @(posedge Clk_CPU);
      model_step(irq_v, we_v, a, wd, ack_v);
      @(negedge Clk_CPU);
      check_outputs();
   endtask

   // Asynchronous reset asserted between clock edges
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check_val("rst_ireq",   {31'd0, bus.Ireq_o},   32'd0);
      check_val("rst_active", {31'd0, bus.active_o}, 32'd0);
      check_val("rst_cause",  {30'd0, bus.cause_o},  32'd0);
      model_reset();
      @(posedge Clk_CPU);
      @(negedge Clk_CPU);
      rst = 1'b0;
      check_outputs();
   endtask

   initial begin
      logic [3:0]  r_irq;
      logic        we_v, ack_v;
      logic [1:0]  a;
      logic [31:0] wd, t;

      bus.we_i = 1'b0; bus.addr_i = 2'd0; bus.wdata_i = 32'd0; bus.Iack_i = 1'b0;
      model_reset();
      repeat (2) @(posedge Clk_CPU);
      @(negedge Clk_CPU);
      rst = 1'b0;
      check_outputs();
      step(4'd0, 1'b0, 2'd0, 32'd0, 1'b0);
      check_val("rst_mask", bus.rdata_o, 32'h0);
      step(4'd0, 1'b0, 2'd3, 32'd0, 1'b0);
      check_val("rst_edge", bus.rdata_o, 32'hF);

      // Single masked-in edge source through the full handshake
      step(4'd0, 1'b1, 2'd0, 32'd4, 1'b0);
      repeat (3) step(4'd4, 1'b0, 2'd1, 32'd0, 1'b0);
      check_val("p1_pend", bus.rdata_o, 32'd4);
      check_val("p1_noreq", {31'd0, bus.Ireq_o}, 32'd0);
      step(4'd4, 1'b0, 2'd1, 32'd0, 1'b0);
      check_val("p1_req", {31'd0, bus.Ireq_o}, 32'd1);
      step(4'd4, 1'b0, 2'd1, 32'd0, 1'b1);
      check_val("p1_cause", {30'd0, bus.cause_o}, 32'd2);
      check_val("p1_clr", bus.rdata_o, 32'd0);
      check_val("p1_act", {31'd0, bus.active_o}, 32'd1);
      step(4'd4, 1'b1, 2'd2, 32'd0, 1'b0);
      check_val("p1_eoi", {31'd0, bus.active_o}, 32'd0);

      // Two simultaneous edges: lowest index first, the other re-requests
      step(4'd0, 1'b1, 2'd0, 32'hF, 1'b0);
      repeat (2) step(4'd0, 1'b0, 2'd1, 32'd0, 1'b0);
      repeat (4) step(4'b1010, 1'b0, 2'd1, 32'd0, 1'b0);
      step(4'b1010, 1'b0, 2'd1, 32'd0, 1'b1);
      check_val("p2_cause1", {30'd0, bus.cause_o}, 32'd1);
      check_val("p2_pend", bus.rdata_o, 32'b1000);
      step(4'b1010, 1'b1, 2'd2, 32'd0, 1'b0);
      step(4'b1010, 1'b0, 2'd1, 32'd0, 1'b0);
      check_val("p2_rereq", {31'd0, bus.Ireq_o}, 32'd1);
      step(4'b1010, 1'b0, 2'd1, 32'd0, 1'b1);
      check_val("p2_cause3", {30'd0, bus.cause_o}, 32'd3);

      // W1C in the same cycle as a new edge: the set wins
      repeat (3) step(4'b0000, 1'b0, 2'd1, 32'd0, 1'b0);
      repeat (2) step(4'b0010, 1'b0, 2'd1, 32'd0, 1'b0);
      step(4'b0010, 1'b1, 2'd1, 32'd2, 1'b0);
      check_val("set_wins", {31'd0, bus.rdata_o[1]}, 32'd1);
      step(4'b0010, 1'b1, 2'd2, 32'd0, 1'b0);

      // Randomized run against the model, with occasional async resets
      r_irq = 4'd0;
      for (int c = 0; c < 4000; c++) begin
         t = $urandom;
         for (int b = 0; b < 4; b++)
            if (((t >> (b * 3)) & 32'd7) == 32'd0) r_irq[b] = ~r_irq[b];
         we_v = ($urandom_range(0, 3) == 0);
         a    = 2'($urandom_range(0, 3));
         wd   = $urandom;
         if (m_mode == 1 && (m_pend & m_mask) != 4'd0)
            ack_v = ($urandom_range(0, 1) == 1);
         else if (m_mode == 1)
            ack_v = 1'b0;
         else
            ack_v = ($urandom_range(0, 7) == 0);
         step(r_irq, we_v, a, wd, ack_v);
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      // Reset while a request is outstanding
      step(4'd0, 1'b1, 2'd3, 32'hF, 1'b0);
      step(4'd0, 1'b1, 2'd0, 32'hF, 1'b0);
      repeat (3) step(4'd0, 1'b0, 2'd1, 32'd0, 1'b0);
      repeat (4) step(4'd1, 1'b0, 2'd1, 32'd0, 1'b0);
      check_val("r_inreq", {31'd0, bus.Ireq_o}, 32'd1);
      do_reset();
      check_val("r_pend", bus.rdata_o, 32'd0);
      step(4'd1, 1'b0, 2'd0, 32'd0, 1'b0);
      check_val("r_mask", bus.rdata_o, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
